// File: rtl/note_render_pkg.sv
// Shared types and helpers for the note layer renderer: slot record, screen
// constants and the pitch-to-row mapping.
package note_render_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [3:0] pitch;
  } note_slot_t;

  // Top row of a note head; an underflow wraps high and is rejected as off-screen.
  function automatic logic [10:0] pitch_to_y(input logic [3:0] pitch,
                                             input int unsigned staff_top,
                                             input int unsigned line_spacing,
                                             input int unsigned note_h);
    return 11'(staff_top + pitch * (line_spacing / 2) - note_h / 2);
  endfunction

endpackage

// File: rtl/note_layer_renderer_if.sv
// Note-table bus: shadow writes, commit/scroll control and commit status.
interface note_layer_renderer_if #(
  parameter int unsigned NUM_NOTES = 8
);
  localparam int unsigned AW = $clog2(NUM_NOTES);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [9:0]    wr_x;
  logic [3:0]    wr_pitch;
  logic          wr_valid;
  logic          commit;
  logic          scroll_en;
  logic          commit_pending;

  modport master (
    output wr_en, wr_addr, wr_x, wr_pitch, wr_valid, commit, scroll_en,
    input  commit_pending
  );

  modport slave (
    input  wr_en, wr_addr, wr_x, wr_pitch, wr_valid, commit, scroll_en,
    output commit_pending
  );
endinterface

// File: rtl/note_hit_test.sv
// Combinational test of one note slot against the current pixel, after
// applying the scroll offset and on-screen visibility rules.
module note_hit_test import note_render_pkg::*; #(
  parameter int unsigned HVisible    = 640,
  parameter int unsigned StaffTop    = 100,
  parameter int unsigned LineSpacing = 12,
  parameter int unsigned NoteW       = 8,
  parameter int unsigned NoteH       = 6
) (
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  input  note_slot_t slot_i,
  input  logic [9:0] offset_i,
  output logic       hit_o
);

  logic [9:0]  x_disp;
  logic [10:0] note_y;
  logic        drawable;
  logic        x_in;
  logic        y_in;

  always_comb begin
    x_disp   = slot_i.x - offset_i;
    note_y   = pitch_to_y(slot_i.pitch, StaffTop, LineSpacing, NoteH);
    drawable = slot_i.valid && (32'(x_disp) < HVisible) && (32'(note_y) < V_VISIBLE);
    // Widened so a head near x=1023 or a high row cannot wrap past the pixel.
    x_in     = (11'(draw_x_i) >= 11'(x_disp)) && (11'(draw_x_i) < 11'(x_disp) + 11'(NoteW));
    y_in     = (12'(draw_y_i) >= 12'(note_y)) && (12'(draw_y_i) < 12'(note_y) + 12'(NoteH));
    hit_o    = drawable && x_in && y_in;
  end

endmodule

// File: rtl/note_layer_renderer.sv
// Per-pixel colour for staff lines plus scrolling note heads, with a shadow
// note table committed to the display table only at frame start.
module note_layer_renderer #(
  parameter int unsigned NUM_NOTES    = 8,
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned STAFF_TOP    = 100,
  parameter int unsigned LINE_SPACING = 12,
  parameter int unsigned NUM_LINES    = 5,
  parameter int unsigned NOTE_W       = 8,
  parameter int unsigned NOTE_H       = 6,
  parameter logic [11:0] NOTE_RGB     = 12'hF80
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pix_en,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_start,
  note_layer_renderer_if.slave bus,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);
  import note_render_pkg::*;

  localparam int unsigned ChMax = (1 << COLOR_W) - 1;
  localparam logic [COLOR_W-1:0] NoteR = COLOR_W'(NOTE_RGB[11:8] * ChMax / 15);
  localparam logic [COLOR_W-1:0] NoteG = COLOR_W'(NOTE_RGB[7:4] * ChMax / 15);
  localparam logic [COLOR_W-1:0] NoteB = COLOR_W'(NOTE_RGB[3:0] * ChMax / 15);

  note_slot_t shadow_q [NUM_NOTES];
  note_slot_t shadow_d [NUM_NOTES];
  note_slot_t disp_q   [NUM_NOTES];
  note_slot_t disp_d   [NUM_NOTES];
  logic       pending_q, pending_d;
  logic [9:0] offset_q, offset_d;
  logic       s1_blank_q, s1_blank_d;
  logic       s1_staff_q, s1_staff_d;
  logic       s1_note_q, s1_note_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic [NUM_NOTES-1:0] hit;
  logic                 staff_hit;
  logic                 copy;

  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_slot
    note_hit_test #(
      .HVisible    (H_VISIBLE),
      .StaffTop    (STAFF_TOP),
      .LineSpacing (LINE_SPACING),
      .NoteW       (NOTE_W),
      .NoteH       (NOTE_H)
    ) u_hit (
      .draw_x_i (DrawX),
      .draw_y_i (DrawY),
      .slot_i   (disp_q[i]),
      .offset_i (offset_q),
      .hit_o    (hit[i])
    );
  end

  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    offset_d  = offset_q;
    copy      = frame_start && (pending_q || bus.commit);

    if (bus.wr_en) begin
      shadow_d[bus.wr_addr] = '{valid: bus.wr_valid, x: bus.wr_x, pitch: bus.wr_pitch};
    end
    // Copy from the pre-write shadow so a same-cycle write waits for the next commit.
    if (copy) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end else if (bus.commit) begin
      pending_d = 1'b1;
    end
    if (frame_start && bus.scroll_en) begin
      offset_d = offset_q + 10'd1;
    end

    staff_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_LINES; k++) begin
      if (32'(DrawY) == STAFF_TOP + k * LINE_SPACING) staff_hit = 1'b1;
    end

    s1_blank_d = s1_blank_q;
    s1_staff_d = s1_staff_q;
    s1_note_d  = s1_note_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    if (pix_en) begin
      s1_blank_d = blank;
      s1_staff_d = staff_hit;
      s1_note_d  = |hit;
      if (!s1_blank_q) begin
        {red_d, green_d, blue_d} = '0;
      end else if (s1_note_q) begin
        {red_d, green_d, blue_d} = {NoteR, NoteG, NoteB};
      end else if (s1_staff_q) begin
        {red_d, green_d, blue_d} = '1;
      end else begin
        {red_d, green_d, blue_d} = '0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow_q   <= '{default: '0};
      disp_q     <= '{default: '0};
      pending_q  <= 1'b0;
      offset_q   <= '0;
      s1_blank_q <= 1'b0;
      s1_staff_q <= 1'b0;
      s1_note_q  <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      shadow_q   <= shadow_d;
      disp_q     <= disp_d;
      pending_q  <= pending_d;
      offset_q   <= offset_d;
      s1_blank_q <= s1_blank_d;
      s1_staff_q <= s1_staff_d;
      s1_note_q  <= s1_note_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
    end
  end

  assign bus.commit_pending = pending_q;
  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule
